// File: rtl/prog_counter.sv
// Terminal-count timer: programmable threshold, start/clear control, periodic or one-shot mode.
// Optional prescaler is compiled in with `define PROG_COUNTER_PRESCALE_EN.
module prog_counter #(
    parameter int unsigned WIDTH             = 8,
    parameter int unsigned DEFAULT_THRESHOLD = 100,
    parameter int unsigned PRESC_WIDTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   start,
    input  logic                   clr,
    input  logic                   cfg_we,
    input  logic [WIDTH-1:0]       cfg_threshold,
    input  logic                   cfg_oneshot,
`ifdef PROG_COUNTER_PRESCALE_EN
    input  logic [PRESC_WIDTH-1:0] cfg_presc,
`endif
    output logic [WIDTH-1:0]       count,
    output logic                   out_en,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [WIDTH-1:0]       THR_RESET = WIDTH'(DEFAULT_THRESHOLD);
    localparam logic [WIDTH-1:0]       ONE       = WIDTH'(1);
    localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = PRESC_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic [WIDTH-1:0]       thr_q, thr_d;
    logic                   oneshot_q, oneshot_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic [PRESC_WIDTH-1:0] presc_wdata;

    logic cfg_ok;
    logic tick;
    logic advance;
    logic terminal;

`ifdef PROG_COUNTER_PRESCALE_EN
    assign presc_wdata = cfg_presc;
`else
    // presc_q is then held at 0, so tick is constantly 1 and the prescaler folds away.
    assign presc_wdata = '0;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        count_d     = count_q;
        thr_d       = thr_q;
        oneshot_d   = oneshot_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;

        cfg_ok   = cfg_we && (state_q != ST_RUN);
        tick     = (presc_cnt_q == presc_q);
        advance  = (state_q == ST_RUN) && en && tick && !clr && !start;
        terminal = (count_q == (thr_q - ONE));

        if (cfg_ok) begin
            thr_d     = (cfg_threshold == '0) ? ONE : cfg_threshold;
            oneshot_d = cfg_oneshot;
            presc_d   = presc_wdata;
        end

        if (clr || start) begin
            presc_cnt_d = '0;
        end else if ((state_q == ST_RUN) && en) begin
            presc_cnt_d = tick ? '0 : (presc_cnt_q + PRESC_ONE);
        end

        if (clr) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (start) begin
            state_d = ST_RUN;
            count_d = '0;
        end else if (advance) begin
            if (terminal) begin
                count_d = '0;
                if (oneshot_q) begin
                    state_d = ST_DONE;
                end
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            thr_q       <= THR_RESET;
            oneshot_q   <= 1'b0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            thr_q       <= thr_d;
            oneshot_q   <= oneshot_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
        end
    end

    assign count  = count_q;
    assign out_en = advance && terminal;
    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: directed scenarios plus random traffic against a
// reference model that tracks advancing cycles since start and derives count by modulo.
module tb_prog_counter;

    localparam int WIDTH   = 8;
    localparam int DEF_THR = 100;

    logic             clk = 1'b0;
    logic             rst, en, start, clr, cfg_we, cfg_oneshot;
    logic [WIDTH-1:0] cfg_threshold;
    logic [WIDTH-1:0] count;
    logic             out_en, busy, done;

    int total = 0;
    int bad   = 0;

    // reference model
    bit m_run, m_done, m_oneshot;
    int m_thr, m_elapsed;
    logic [WIDTH-1:0] e_count;
    logic e_out, e_busy, e_done;

    prog_counter #(.WIDTH(WIDTH), .DEFAULT_THRESHOLD(DEF_THR), .PRESC_WIDTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .start         (start),
        .clr           (clr),
        .cfg_we        (cfg_we),
        .cfg_threshold (cfg_threshold),
        .cfg_oneshot   (cfg_oneshot),
`ifdef PROG_COUNTER_PRESCALE_EN
        .cfg_presc     (4'd0),
`endif
        .count         (count),
        .out_en        (out_en),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Drive inputs just after the falling edge and compute the expected outputs.
    task automatic apply(input logic r, input logic e, input logic s, input logic c,
                         input logic w, input logic [WIDTH-1:0] t, input logic o);
        rst = r; en = e; start = s; clr = c; cfg_we = w; cfg_threshold = t; cfg_oneshot = o;
        #1;
        e_count = WIDTH'(m_elapsed % m_thr);
        e_out   = m_run && e && !c && !s && ((m_elapsed % m_thr) == (m_thr - 1));
        e_busy  = m_run;
        e_done  = m_done;
    endtask

    // Advance one clock and move the model by the rules of the timer.
    task automatic tick_clk();
        bit adv;
        @(posedge clk);
        adv = m_run && en && !clr && !start;
        if (rst) begin
            m_run = 0; m_done = 0; m_oneshot = 0; m_thr = DEF_THR; m_elapsed = 0;
        end else begin
            if (cfg_we && !m_run) begin
                m_thr     = (cfg_threshold == 0) ? 1 : int'(cfg_threshold);
                m_oneshot = cfg_oneshot;
            end
            if (clr) begin
                m_run = 0; m_done = 0; m_elapsed = 0;
            end else if (start) begin
                m_run = 1; m_done = 0; m_elapsed = 0;
            end else if (adv) begin
                m_elapsed++;
                if (m_oneshot && m_elapsed == m_thr) begin
                    m_run = 0; m_done = 1; m_elapsed = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    // Stimulus only: configure from idle/done and issue a start.
    task automatic cfg_and_start(input logic [WIDTH-1:0] t, input logic o);
        apply(0, 1, 0, 1, 0, 0, 0); tick_clk();
        apply(0, 1, 0, 0, 1, t, o); tick_clk();
        apply(0, 1, 1, 0, 0, 0, 0); tick_clk();
    endtask

    task automatic test_reset();
        int first;
        apply(1, 1, 0, 0, 0, 0, 0); tick_clk();
        apply(1, 1, 0, 0, 0, 0, 0);
        total++;
        if ({count, out_en, busy, done} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got cnt=%0d out=%b busy=%b done=%b exp 0 0 0 0", count, out_en, busy, done);
        end
        tick_clk();
        for (int k = 0; k < 5; k++) begin
            apply(0, 1, 0, 0, 0, 0, 0);
            total++;
            if ({count, out_en, busy, done} !== {e_count, e_out, e_busy, e_done}) begin
                bad++;
                $display("FAIL reset_idle k=%0d got %0d/%b/%b/%b exp %0d/%b/%b/%b", k, count, out_en, busy, done, e_count, e_out, e_busy, e_done);
            end
            tick_clk();
        end
        apply(0, 1, 1, 0, 0, 0, 0); tick_clk();
        first = -1;
        for (int k = 1; k <= 110; k++) begin
            apply(0, 1, 0, 0, 0, 0, 0);
            total++;
            if ({count, out_en, busy, done} !== {e_count, e_out, e_busy, e_done}) begin
                bad++;
                $display("FAIL default_period k=%0d got %0d/%b/%b/%b exp %0d/%b/%b/%b", k, count, out_en, busy, done, e_count, e_out, e_busy, e_done);
            end
            if (out_en === 1'b1 && first < 0) first = k;
            tick_clk();
        end
        total++;
        if (first != DEF_THR) begin
            bad++;
            $display("FAIL default_first_pulse got=%0d exp=%0d", first, DEF_THR);
        end
    endtask

    task automatic test_periodic();
        int pulses, last;
        cfg_and_start(8'd5, 1'b0);
        pulses = 0; last = -1;
        for (int k = 1; k <= 20; k++) begin
            apply(0, 1, 0, 0, 0, 0, 0);
            total++;
            if ({count, out_en, busy, done} !== {e_count, e_out, e_busy, e_done} || busy !== 1'b1) begin
                bad++;
                $display("FAIL periodic k=%0d got %0d/%b/%b/%b exp %0d/%b/1/%b", k, count, out_en, busy, done, e_count, e_out, e_done);
            end
            if (out_en === 1'b1) begin pulses++; last = k; end
            tick_clk();
        end
        total++;
        if (pulses != 4 || last != 20) begin
            bad++;
            $display("FAIL periodic_pulses got=%0d last=%0d exp=4 last=20", pulses, last);
        end
    endtask

    task automatic test_oneshot();
        int pulses, at;
        cfg_and_start(8'd3, 1'b1);
        for (int run = 0; run < 2; run++) begin
            pulses = 0; at = -1;
            for (int k = 1; k <= 8; k++) begin
                apply(0, 1, 0, 0, 0, 0, 0);
                total++;
                if ({count, out_en, busy, done} !== {e_count, e_out, e_busy, e_done}) begin
                    bad++;
                    $display("FAIL oneshot run=%0d k=%0d got %0d/%b/%b/%b exp %0d/%b/%b/%b", run, k, count, out_en, busy, done, e_count, e_out, e_busy, e_done);
                end
                if (out_en === 1'b1) begin pulses++; at = k; end
                tick_clk();
            end
            total++;
            if (pulses != 1 || at != 3 || done !== 1'b1 || busy !== 1'b0 || count !== 8'd0) begin
                bad++;
                $display("FAIL oneshot_end run=%0d got pulses=%0d at=%0d done=%b busy=%b cnt=%0d exp 1 3 1 0 0", run, pulses, at, done, busy, count);
            end
            apply(0, 1, 1, 0, 0, 0, 0); tick_clk();
        end
    endtask

    task automatic test_enable_gap();
        int first, pulses;
        logic e;
        cfg_and_start(8'd4, 1'b0);
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            e = !(k >= 3 && k <= 5);
            apply(0, e, 0, 0, 0, 0, 0);
            total++;
            if ({count, out_en, busy, done} !== {e_count, e_out, e_busy, e_done}) begin
                bad++;
                $display("FAIL en_gap k=%0d got %0d/%b/%b/%b exp %0d/%b/%b/%b", k, count, out_en, busy, done, e_count, e_out, e_busy, e_done);
            end
            if (out_en === 1'b1 && first < 0) first = k;
            tick_clk();
        end
        total++;
        if (first != 7) begin
            bad++;
            $display("FAIL en_gap_delay got=%0d exp=7", first);
        end
        for (int t = 0; t < 2; t++) begin
            cfg_and_start(WIDTH'(1 - t), 1'b0);
            pulses = 0;
            for (int k = 1; k <= 6; k++) begin
                apply(0, 1, 0, 0, 0, 0, 0);
                total++;
                if ({count, out_en} !== {8'd0, 1'b1} || {busy, done} !== {e_busy, e_done}) begin
                    bad++;
                    $display("FAIL thr_one wr=%0d k=%0d got cnt=%0d out=%b exp cnt=0 out=1", 1 - t, k, count, out_en);
                end
                if (out_en === 1'b1) pulses++;
                tick_clk();
            end
        end
        cfg_and_start(8'd255, 1'b0);
        first = -1; pulses = 0;
        for (int k = 1; k <= 520; k++) begin
            apply(0, 1, 0, 0, 0, 0, 0);
            total++;
            if ({count, out_en, busy, done} !== {e_count, e_out, e_busy, e_done}) begin
                bad++;
                $display("FAIL thr_max k=%0d got %0d/%b exp %0d/%b", k, count, out_en, e_count, e_out);
            end
            if (out_en === 1'b1) begin pulses++; if (first < 0) first = k; end
            tick_clk();
        end
        total++;
        if (first != 255 || pulses != 2) begin
            bad++;
            $display("FAIL thr_max_period got first=%0d pulses=%0d exp 255 2", first, pulses);
        end
    endtask

    task automatic test_collisions();
        int pulses, first;
        cfg_and_start(8'd5, 1'b0);
        pulses = 0;
        for (int k = 1; k <= 15; k++) begin
            apply(0, 1, 0, 0, (k == 2), 8'd2, 1'b1);
            total++;
            if ({count, out_en, busy, done} !== {e_count, e_out, e_busy, e_done}) begin
                bad++;
                $display("FAIL cfg_in_run k=%0d got %0d/%b/%b/%b exp %0d/%b/%b/%b", k, count, out_en, busy, done, e_count, e_out, e_busy, e_done);
            end
            if (out_en === 1'b1) pulses++;
            tick_clk();
        end
        total++;
        if (pulses != 3) begin
            bad++;
            $display("FAIL cfg_in_run_pulses got=%0d exp=3", pulses);
        end
        apply(0, 1, 1, 1, 0, 0, 0); tick_clk();
        apply(0, 1, 0, 0, 0, 0, 0);
        total++;
        if ({count, busy, done} !== {8'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL clr_start got cnt=%0d busy=%b done=%b exp 0 0 0", count, busy, done);
        end
        tick_clk();
        cfg_and_start(8'd4, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            apply(0, 1, (k == 4), 0, 0, 0, 0);
            total++;
            if ({count, out_en, busy, done} !== {e_count, e_out, e_busy, e_done} || (k == 4 && out_en !== 1'b0)) begin
                bad++;
                $display("FAIL restart k=%0d got %0d/%b exp %0d/%b", k, count, out_en, e_count, e_out);
            end
            tick_clk();
        end
        cfg_and_start(8'd10, 1'b0);
        for (int k = 1; k <= 7; k++) begin apply(0, 1, 0, 0, 0, 0, 0); tick_clk(); end
        apply(1, 1, 0, 0, 0, 0, 0);
        total++;
        if (count !== 8'd7) begin
            bad++;
            $display("FAIL pre_rst_count got=%0d exp=7", count);
        end
        tick_clk();
        apply(0, 1, 1, 0, 0, 0, 0);
        total++;
        if ({count, busy, done} !== {8'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rst_mid_run got cnt=%0d busy=%b done=%b exp 0 0 0", count, busy, done);
        end
        tick_clk();
        first = -1;
        for (int k = 1; k <= 105; k++) begin
            apply(0, 1, 0, 0, 0, 0, 0);
            if (out_en === 1'b1 && first < 0) first = k;
            tick_clk();
        end
        total++;
        if (first != DEF_THR) begin
            bad++;
            $display("FAIL rst_thr_default got=%0d exp=%0d", first, DEF_THR);
        end
    endtask

    task automatic test_random();
        logic r, e, s, c, w, o;
        logic [WIDTH-1:0] t;
        for (int k = 0; k < 600; k++) begin
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 19) == 0);
            c = ($urandom_range(0, 39) == 0);
            w = ($urandom_range(0, 5) == 0);
            t = WIDTH'($urandom_range(0, 9));
            o = $urandom_range(0, 1) == 1;
            apply(r, e, s, c, w, t, o);
            if (k > 0) begin
                total++;
                if ({count, out_en, busy, done} !== {e_count, e_out, e_busy, e_done}) begin
                    bad++;
                    $display("FAIL random k=%0d got %0d/%b/%b/%b exp %0d/%b/%b/%b", k, count, out_en, busy, done, e_count, e_out, e_busy, e_done);
                end
            end
            tick_clk();
        end
    endtask

    initial begin
        m_run = 0; m_done = 0; m_oneshot = 0; m_thr = DEF_THR; m_elapsed = 0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_enable_gap();
        test_collisions();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Next-generation terminal-count timer: WIDTH-bit counter with run-time programmable threshold, start/clear control, periodic or one-shot mode, and a one-cycle terminal pulse.
- Used as the shared enable/tick source for datapath blocks in the lab designs, replacing fixed-threshold counters.

Parameters:
- WIDTH, 8, counter and threshold width in bits.
- DEFAULT_THRESHOLD, 100, threshold value loaded on reset; must be between 1 and 2^WIDTH-1.
- PRESC_WIDTH, 4, prescaler width in bits; used only when PROG_COUNTER_PRESCALE_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global count enable; low freezes counting.
- start  input  1  single-cycle start request.
- clr  input  1  synchronous clear to IDLE.
- cfg_we  input  1  configuration write strobe.
- cfg_threshold  input  WIDTH  period value (terminal count + 1).
- cfg_oneshot  input  1  1 = one-shot, 0 = periodic; latched with cfg_we.
- count  output  WIDTH  current count value.
- out_en  output  1  terminal pulse, combinational.
- busy  output  1  high in RUN.
- done  output  1  high in DONE (one-shot completed).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Registers: state, count, thr_q, oneshot_q.
  - Reset values: state=IDLE, count=0, thr_q=DEFAULT_THRESHOLD, oneshot_q=0.
  - Output reset values: out_en=0, busy=0, done=0.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
- Priority per cycle: rst > clr > start > advance.
- clr:
  - From any state: state=IDLE, count=0.
  - thr_q and oneshot_q are kept.
- start:
  - From IDLE or DONE: state=RUN, count=0 next cycle.
  - In RUN: restarts, count=0; no out_en that cycle.
  - start is accepted regardless of en.
- tick: constant 1 unless the optional feature is compiled in.
- advance = (state==RUN) && en && tick && !clr && !start.
- Counting:
  - On advance with count < thr_q-1: count <= count+1.
  - On advance with count == thr_q-1: out_en=1 in that cycle, count <= 0.
    - Periodic mode: stay in RUN.
    - One-shot mode: state <= DONE.
- out_en = advance && (count == thr_q-1). Exactly one cycle per period; 0 whenever en=0 or the state is not RUN.
- Period: thr_q advancing cycles per out_en pulse. First out_en arrives thr_q cycles after the start cycle when en=1 continuously.
- thr_q==1: out_en on every advancing cycle; count stays 0.
- cfg_we:
  - Accepted only in IDLE or DONE; ignored in RUN, so there is no mid-period change.
  - A cfg_threshold of 0 is stored as 1.
  - cfg_we and start in the same cycle: the new configuration is used by that run.
- Arithmetic: all compares in WIDTH bits; thr_q-1 never underflows because thr_q>=1. Maximum period is 2^WIDTH-1.
- en low mid-run: count, state and the prescaler hold; resume exactly where they stopped.
- rst mid-run: all registers return to reset values next cycle, including thr_q back to DEFAULT_THRESHOLD.

Optional Feature:
- Macro: PROG_COUNTER_PRESCALE_EN.
- Defined:
  - Adds input cfg_presc [PRESC_WIDTH], latched into presc_q on an accepted cfg_we; presc_q resets to 0.
  - An internal prescaler counts enabled RUN cycles, 0..presc_q.
  - tick=1 when prescaler==presc_q, after which the prescaler wraps to 0.
  - The prescaler is cleared on rst, clr and start, and frozen when en=0.
  - Period becomes thr_q*(presc_q+1) cycles.
- Undefined: cfg_presc port absent; tick constant 1; behaviour identical to presc_q=0.

Test Plan:
- Reset check: rst high 2 cycles, en=1, no start -> count=0, state IDLE, busy=0, out_en never asserts; thr_q=100 (default period observed after start).
- Periodic period: write threshold 5, periodic; start; en=1 for 20 cycles -> count 0,1,2,3,4,0...; out_en high on cycles 5,10,15,20 after start; busy=1 throughout.
- One-shot: write threshold 3, oneshot=1; start -> out_en once at cycle 3, then done=1, busy=0, count=0; no further pulses; a second start restarts and produces one more pulse.
- Enable gap and threshold boundaries:
  - Threshold 4; drop en for 3 cycles at count=2 -> count holds 2, out_en=0; pulse is delayed by 3 cycles.
  - Threshold 1 -> out_en every cycle.
  - Write of 0 -> behaves as 1.
  - Threshold 255 with WIDTH=8 -> period 255.
- Control collisions:
  - cfg_we during RUN -> ignored; period unchanged.
  - clr and start in the same cycle -> IDLE.
  - start in RUN at count=3 -> count=0, no pulse that cycle.
  - rst at count=7 -> count=0, thr_q=100.
- With PROG_COUNTER_PRESCALE_EN: threshold 3, presc 1 -> out_en every 6 cycles; en toggling freezes the prescaler with no lost or extra ticks.
